// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - heading encoding and shared helpers for the snake direction controller
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_LEFT  = 2'd3
    } dir_t;

    localparam int DEFAULT_QUEUE_DEPTH = 4;

    // Two headings are opposite when they differ only in the high bit.
    function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
        return (a ^ b) == 2'b10;
    endfunction

endpackage

// File: rtl/dir_fifo.sv
// rtl/dir_fifo.sv - small queue of pending headings with head and tail visibility
module dir_fifo #(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  logic [1:0]    wdata,
    output logic [1:0]    rdata,
    output logic [1:0]    tail,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [1:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];
    assign tail  = mem_q[wr_ptr_q - PW'(1)];

    // A full queue still accepts a write when the head leaves in the same cycle.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Next pointers and occupancy; flush empties the queue regardless of traffic.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; only the slot under the write pointer changes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 2'd0;
        end else if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/snake_dir_ctrl.sv
// rtl/snake_dir_ctrl.sv - button edges to filtered, queued snake heading changes
module snake_dir_ctrl
    import snake_pkg::*;
#(
    parameter int         QUEUE_DEPTH = DEFAULT_QUEUE_DEPTH,
    parameter logic [1:0] INIT_DIR    = 2'd1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               btn_up,
    input  logic                               btn_right,
    input  logic                               btn_down,
    input  logic                               btn_left,
    input  logic                               game_tick,
    input  logic                               restart,
    output logic [1:0]                         dir,
    output logic                               turn_applied,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   q_count,
    output logic                               overflow
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    // Bit index matches the heading encoding: 0=UP .. 3=LEFT.
    logic [3:0]    btn_vec;
    logic [3:0]    btn_q;
    logic [3:0]    btn_event;
    logic [1:0]    dir_q, dir_d;
    logic          turn_applied_q, turn_applied_d;
    logic          overflow_q, overflow_d;

    logic          has_event;
    logic [1:0]    cand;
    logic [1:0]    ref_dir;
    logic          accept;
    logic          fifo_push;
    logic          fifo_pop;
    logic [1:0]    fifo_rdata;
    logic [1:0]    fifo_tail;
    logic [CW-1:0] fifo_count;
    logic          fifo_full;
    logic          fifo_empty;

    assign btn_vec   = {btn_left, btn_down, btn_right, btn_up};
    assign btn_event = btn_vec & ~btn_q;

    dir_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (restart),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (cand),
        .rdata (fifo_rdata),
        .tail  (fifo_tail),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Pick the highest-priority new press, filter it against the last planned heading,
    // and work out the heading/flag updates for this cycle.
    always_comb begin
        has_event      = |btn_event;
        cand           = DIR_UP;
        if (btn_event[0])      cand = DIR_UP;
        else if (btn_event[1]) cand = DIR_RIGHT;
        else if (btn_event[2]) cand = DIR_DOWN;
        else if (btn_event[3]) cand = DIR_LEFT;

        // Compare against the newest queued turn so chained presses are judged in order.
        ref_dir        = fifo_empty ? dir_q : fifo_tail;
        accept         = has_event && (cand != ref_dir) && !is_reverse(cand, ref_dir);

        fifo_pop       = game_tick & ~fifo_empty & ~restart;
        fifo_push      = accept & ~restart & (~fifo_full | fifo_pop);

        dir_d          = dir_q;
        turn_applied_d = 1'b0;
        overflow_d     = overflow_q;
        if (restart) begin
            dir_d      = INIT_DIR;
            overflow_d = 1'b0;
        end else begin
            if (fifo_pop) begin
                dir_d          = fifo_rdata;
                turn_applied_d = 1'b1;
            end
            if (accept && fifo_full && !fifo_pop) overflow_d = 1'b1;
        end
    end

    // Heading, turn strobe, sticky overflow and button history registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_q          <= '0;
            dir_q          <= INIT_DIR;
            turn_applied_q <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            btn_q          <= btn_vec;
            dir_q          <= dir_d;
            turn_applied_q <= turn_applied_d;
            overflow_q     <= overflow_d;
        end
    end

    assign dir          = dir_q;
    assign turn_applied = turn_applied_q;
    assign q_count      = fifo_count;
    assign overflow     = overflow_q;

endmodule
